// File: rtl/reset_supervisor_mips_if.sv
// Request/status bundle between the reset supervisor and its controlling logic.
// master drives the reset requests; slave (the supervisor) drives reset and status.
interface reset_supervisor_mips_if #(
  parameter int unsigned CNT_W = 8
);
  logic             i_wdt_rst;
  logic             i_sw_rst_req;
  logic             i_cause_clr;
  logic             o_core_reset;
  logic [1:0]       o_rst_cause;
  logic [CNT_W-1:0] o_wdt_rst_count;
  logic             o_rst_release;

  modport master (
    output i_wdt_rst, i_sw_rst_req, i_cause_clr,
    input  o_core_reset, o_rst_cause, o_wdt_rst_count, o_rst_release
  );

  modport slave (
    input  i_wdt_rst, i_sw_rst_req, i_cause_clr,
    output o_core_reset, o_rst_cause, o_wdt_rst_count, o_rst_release
  );
endinterface

// File: rtl/reset_supervisor_mips.sv
// Core reset supervisor: synchronised POR release, stretched WDT/SW resets, sticky cause, WDT count.
// Define RST_SUP_SYNC_REQ_EN to pass the reset requests through 2-flop synchronisers.
module reset_supervisor_mips #(
  parameter int unsigned RST_HOLD_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  reset_supervisor_mips_if.slave       bus
);
  localparam int unsigned HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_POR  = 2'b01;
  localparam logic [1:0] CAUSE_WDT  = 2'b10;
  localparam logic [1:0] CAUSE_SW   = 2'b11;

  typedef enum logic {ST_HOLD = 1'b0, ST_RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [1:0]         rel_sync_q;
  logic               core_reset_q, core_reset_d;
  logic               release_q, release_d;
  logic [1:0]         cause_q, cause_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               wdt_req, sw_req, any_req;

`ifdef RST_SUP_SYNC_REQ_EN
  logic [1:0] wdt_sync_q, sw_sync_q;

  // Requests may come from another clock domain
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wdt_sync_q <= 2'b00;
      sw_sync_q  <= 2'b00;
    end else begin
      wdt_sync_q <= {wdt_sync_q[0], bus.i_wdt_rst};
      sw_sync_q  <= {sw_sync_q[0], bus.i_sw_rst_req};
    end
  end

  assign wdt_req = wdt_sync_q[1];
  assign sw_req  = sw_sync_q[1];
`else
  assign wdt_req = bus.i_wdt_rst;
  assign sw_req  = bus.i_sw_rst_req;
`endif

  assign any_req = wdt_req | sw_req;

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    core_reset_d = core_reset_q;
    release_d    = 1'b0;
    cause_d      = cause_q;
    count_d      = count_q;
    unique case (state_q)
      ST_HOLD: begin
        core_reset_d = 1'b1;
        // Retrigger leaves cause and count alone so a held level counts once
        if (any_req) begin
          hold_cnt_d = '0;
        end else if (rel_sync_q[1]) begin
          if (hold_cnt_q == HOLD_W'(RST_HOLD_CYCLES - 1)) begin
            state_d      = ST_RUN;
            hold_cnt_d   = '0;
            core_reset_d = 1'b0;
            release_d    = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
      end
      ST_RUN: begin
        core_reset_d = 1'b0;
        if (any_req) begin
          state_d      = ST_HOLD;
          hold_cnt_d   = '0;
          core_reset_d = 1'b1;
          cause_d      = wdt_req ? CAUSE_WDT : CAUSE_SW;
          if (wdt_req && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
          end
        end else if (bus.i_cause_clr) begin
          cause_d = CAUSE_NONE;
        end
      end
    endcase
  end

  // State, release synchroniser and registered outputs
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= ST_HOLD;
      hold_cnt_q   <= '0;
      rel_sync_q   <= 2'b00;
      core_reset_q <= 1'b1;
      release_q    <= 1'b0;
      cause_q      <= CAUSE_POR;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      rel_sync_q   <= {rel_sync_q[0], 1'b1};
      core_reset_q <= core_reset_d;
      release_q    <= release_d;
      cause_q      <= cause_d;
      count_q      <= count_d;
    end
  end

  assign bus.o_core_reset    = core_reset_q;
  assign bus.o_rst_release   = release_q;
  assign bus.o_rst_cause     = cause_q;
  assign bus.o_wdt_rst_count = count_q;
endmodule
